// File: rtl/perf_pkg.sv
// perf_pkg: shared definitions for the performance-history block.
//   - CSR word addresses (read map and the CTRL write address)
//   - CTRL command bit indices and STATUS field positions
//   - perf_record_t: one captured measurement (six 32-bit counters)
//   - sat_add64: saturating 64-bit accumulate of a 32-bit sample
package perf_pkg;

  localparam logic [3:0] PERF_HIST_STATUS     = 4'h0;
  localparam logic [3:0] PERF_HIST_TOTAL      = 4'h1;
  localparam logic [3:0] PERF_HIST_ACTIVE     = 4'h2;
  localparam logic [3:0] PERF_HIST_IDLE       = 4'h3;
  localparam logic [3:0] PERF_HIST_HITS       = 4'h4;
  localparam logic [3:0] PERF_HIST_MISSES     = 4'h5;
  localparam logic [3:0] PERF_HIST_DECODE     = 4'h6;
  localparam logic [3:0] PERF_HIST_CTRL       = 4'h7;
  localparam logic [3:0] PERF_HIST_ACC_TOT_LO = 4'h8;
  localparam logic [3:0] PERF_HIST_ACC_TOT_HI = 4'h9;
  localparam logic [3:0] PERF_HIST_ACC_ACT_LO = 4'hA;
  localparam logic [3:0] PERF_HIST_ACC_ACT_HI = 4'hB;
  localparam logic [3:0] PERF_HIST_RUNCNT     = 4'hC;

  localparam int unsigned CTRL_POP       = 0;
  localparam int unsigned CTRL_CLR_FIFO  = 1;
  localparam int unsigned CTRL_CLR_OVF   = 2;
  localparam int unsigned CTRL_CLR_ACCUM = 3;

  localparam int unsigned STATUS_LEVEL_LSB = 0;
  localparam int unsigned STATUS_LEVEL_MSB = 4;
  localparam int unsigned STATUS_EMPTY     = 8;
  localparam int unsigned STATUS_FULL      = 9;
  localparam int unsigned STATUS_OVERFLOW  = 10;

  typedef struct packed {
    logic [31:0] total;
    logic [31:0] active;
    logic [31:0] idle;
    logic [31:0] hits;
    logic [31:0] misses;
    logic [31:0] decode;
  } perf_record_t;

  // Carry out of the 65-bit sum means the accumulator would wrap; pin it.
  function automatic logic [63:0] sat_add64(input logic [63:0] acc,
                                            input logic [31:0] sample);
    logic [64:0] sum;
    sum = {1'b0, acc} + {33'b0, sample};
    return sum[64] ? '1 : sum[63:0];
  endfunction

endpackage

// File: rtl/perf_hist_fifo.sv
// perf_hist_fifo: synchronous snapshot FIFO of perf_record_t.
//   clk, rst_n      : clock, asynchronous active-low reset
//   push, wr_data   : append a record at the tail
//   pop             : drop the head record (no-op when empty)
//   clear           : empty the FIFO; beats a same-cycle push
//   head            : record at the head (undefined when empty)
//   empty/full/level: occupancy, level in 0..DEPTH
//   overflow        : combinational pulse, push refused because full
module perf_hist_fifo
  import perf_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned LW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic            clear,
  input  perf_record_t    wr_data,
  output perf_record_t    head,
  output logic            empty,
  output logic            full,
  output logic [LW-1:0]   level,
  output logic            overflow
);

  perf_record_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    empty = (level == '0);
    full  = (level == LW'(DEPTH));
    head  = mem[rd_ptr];
  end

  // A pop frees the slot the same-cycle push needs, so full+pop+push is
  // accepted; pop on an empty FIFO never qualifies, leaving push alone.
  always_comb begin
    do_pop   = 1'b0;
    do_push  = 1'b0;
    overflow = 1'b0;
    if (!clear) begin
      do_pop   = pop && !empty;
      do_push  = push && (!full || do_pop);
      overflow = push && full && !do_pop;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      // DEPTH is a power of two, so pointer increment wraps naturally.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset; only entries below level are ever observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/perf_history.sv
// perf_history: captures completed measurement records into a snapshot
// FIFO, keeps saturating lifetime accumulators and exposes both through
// a word-addressed CSR port.
//   clk, rst_n              : clock, asynchronous active-low reset
//   measurement_done        : one-cycle strobe qualifying the six counts
//   *_count                 : measurement counters (COUNTER_WIDTH bits)
//   csr_wr_en/csr_wr_data   : write strobe/data (only CTRL is writable)
//   csr_rd_en               : read strobe
//   csr_addr                : word address shared by read and write
//   csr_rd_data/csr_rd_valid: registered read response, one cycle later
//   irq_pending             : registered FIFO non-empty indication
module perf_history
  import perf_pkg::*;
#(
  parameter int unsigned COUNTER_WIDTH = 32,
  parameter int unsigned DEPTH         = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     measurement_done,
  input  logic [COUNTER_WIDTH-1:0] total_cycles_count,
  input  logic [COUNTER_WIDTH-1:0] active_cycles_count,
  input  logic [COUNTER_WIDTH-1:0] idle_cycles_count,
  input  logic [COUNTER_WIDTH-1:0] cache_hit_count,
  input  logic [COUNTER_WIDTH-1:0] cache_miss_count,
  input  logic [COUNTER_WIDTH-1:0] decode_count,
  input  logic                     csr_wr_en,
  input  logic                     csr_rd_en,
  input  logic [3:0]               csr_addr,
  input  logic [31:0]              csr_wr_data,
  output logic [31:0]              csr_rd_data,
  output logic                     csr_rd_valid,
  output logic                     irq_pending
);

  localparam int unsigned LW = $clog2(DEPTH + 1);

  perf_record_t  in_rec;
  perf_record_t  head;
  logic          fifo_empty;
  logic          fifo_full;
  logic [LW-1:0] fifo_level;
  logic          fifo_ovf;

  logic          ctrl_wr;
  logic          cmd_pop;
  logic          cmd_clr_fifo;
  logic          cmd_clr_ovf;
  logic          cmd_clr_acc;

  logic          overflow_q;
  logic [63:0]   acc_total;
  logic [63:0]   acc_active;
  logic [31:0]   run_count;
  logic [31:0]   rd_mux;
  logic [31:0]   status_word;
  logic          unused_wr_bits;

  always_comb begin
    in_rec.total  = 32'(total_cycles_count);
    in_rec.active = 32'(active_cycles_count);
    in_rec.idle   = 32'(idle_cycles_count);
    in_rec.hits   = 32'(cache_hit_count);
    in_rec.misses = 32'(cache_miss_count);
    in_rec.decode = 32'(decode_count);
  end

  always_comb begin
    ctrl_wr        = csr_wr_en && (csr_addr == PERF_HIST_CTRL);
    cmd_pop        = ctrl_wr && csr_wr_data[CTRL_POP];
    cmd_clr_fifo   = ctrl_wr && csr_wr_data[CTRL_CLR_FIFO];
    cmd_clr_ovf    = ctrl_wr && csr_wr_data[CTRL_CLR_OVF];
    cmd_clr_acc    = ctrl_wr && csr_wr_data[CTRL_CLR_ACCUM];
    unused_wr_bits = ^csr_wr_data[31:4];
  end

  perf_hist_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (measurement_done),
    .pop      (cmd_pop),
    .clear    (cmd_clr_fifo),
    .wr_data  (in_rec),
    .head     (head),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .level    (fifo_level),
    .overflow (fifo_ovf)
  );

  // Sticky overflow: a same-cycle refusal wins over clear_overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           overflow_q <= 1'b0;
    else if (fifo_ovf)    overflow_q <= 1'b1;
    else if (cmd_clr_ovf) overflow_q <= 1'b0;
  end

  // Accumulate every completed run, including ones the FIFO refuses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_total  <= '0;
      acc_active <= '0;
      run_count  <= '0;
    end else if (cmd_clr_acc) begin
      acc_total  <= '0;
      acc_active <= '0;
      run_count  <= '0;
    end else if (measurement_done) begin
      acc_total  <= sat_add64(acc_total, in_rec.total);
      acc_active <= sat_add64(acc_active, in_rec.active);
      if (run_count != '1) run_count <= run_count + 1'b1;
    end
  end

  always_comb begin
    status_word = '0;
    status_word[STATUS_LEVEL_MSB:STATUS_LEVEL_LSB] = 5'(fifo_level);
    status_word[STATUS_EMPTY]    = fifo_empty;
    status_word[STATUS_FULL]     = fifo_full;
    status_word[STATUS_OVERFLOW] = overflow_q;
  end

  always_comb begin
    rd_mux = '0;
    case (csr_addr)
      PERF_HIST_STATUS:     rd_mux = status_word;
      PERF_HIST_TOTAL:      rd_mux = fifo_empty ? '0 : head.total;
      PERF_HIST_ACTIVE:     rd_mux = fifo_empty ? '0 : head.active;
      PERF_HIST_IDLE:       rd_mux = fifo_empty ? '0 : head.idle;
      PERF_HIST_HITS:       rd_mux = fifo_empty ? '0 : head.hits;
      PERF_HIST_MISSES:     rd_mux = fifo_empty ? '0 : head.misses;
      PERF_HIST_DECODE:     rd_mux = fifo_empty ? '0 : head.decode;
      PERF_HIST_ACC_TOT_LO: rd_mux = acc_total[31:0];
      PERF_HIST_ACC_TOT_HI: rd_mux = acc_total[63:32];
      PERF_HIST_ACC_ACT_LO: rd_mux = acc_active[31:0];
      PERF_HIST_ACC_ACT_HI: rd_mux = acc_active[63:32];
      PERF_HIST_RUNCNT:     rd_mux = run_count;
      default:              rd_mux = '0;
    endcase
  end

  // The mux samples pre-edge state, so a read sees the FIFO and
  // accumulators as they were before any same-cycle command or push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csr_rd_data  <= '0;
      csr_rd_valid <= 1'b0;
      irq_pending  <= 1'b0;
    end else begin
      csr_rd_valid <= csr_rd_en;
      if (csr_rd_en) csr_rd_data <= rd_mux;
      irq_pending  <= !fifo_empty;
    end
  end

endmodule

// File: tb/tb_perf_history.sv
module tb_perf_history;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        measurement_done = 1'b0;
  logic [31:0] total_cycles_count = '0;
  logic [31:0] active_cycles_count = '0;
  logic [31:0] idle_cycles_count = '0;
  logic [31:0] cache_hit_count = '0;
  logic [31:0] cache_miss_count = '0;
  logic [31:0] decode_count = '0;
  logic        csr_wr_en = 1'b0;
  logic        csr_rd_en = 1'b0;
  logic [3:0]  csr_addr = '0;
  logic [31:0] csr_wr_data = '0;
  logic [31:0] csr_rd_data;
  logic        csr_rd_valid;
  logic        irq_pending;

  always #5 clk = ~clk;

  perf_history #(
    .COUNTER_WIDTH (32),
    .DEPTH         (DEPTH)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .measurement_done    (measurement_done),
    .total_cycles_count  (total_cycles_count),
    .active_cycles_count (active_cycles_count),
    .idle_cycles_count   (idle_cycles_count),
    .cache_hit_count     (cache_hit_count),
    .cache_miss_count    (cache_miss_count),
    .decode_count        (decode_count),
    .csr_wr_en           (csr_wr_en),
    .csr_rd_en           (csr_rd_en),
    .csr_addr            (csr_addr),
    .csr_wr_data         (csr_wr_data),
    .csr_rd_data         (csr_rd_data),
    .csr_rd_valid        (csr_rd_valid),
    .irq_pending         (irq_pending)
  );

  int errors = 0;
  int checks = 0;

  typedef logic [31:0] rec_t [6];

  // Reference model: a queue of records plus plain-arithmetic totals.
  rec_t        mq[$];
  logic [63:0] m_acc_t;
  logic [63:0] m_acc_a;
  logic [31:0] m_runs;
  bit          m_ovf;
  logic [31:0] last_rd;
  rec_t        zrec;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic rec_t mk(input logic [31:0] t, input logic [31:0] a,
                              input logic [31:0] i, input logic [31:0] h,
                              input logic [31:0] m, input logic [31:0] d);
    rec_t r;
    r[0] = t; r[1] = a; r[2] = i; r[3] = h; r[4] = m; r[5] = d;
    return r;
  endfunction

  function automatic logic [63:0] sat_acc(input logic [63:0] a, input logic [31:0] b);
    logic [63:0] room;
    room = 64'hFFFF_FFFF_FFFF_FFFF - a;
    return (64'(b) > room) ? 64'hFFFF_FFFF_FFFF_FFFF : a + 64'(b);
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] a);
    int unsigned n;
    logic [31:0] v;
    rec_t hd;
    n = mq.size();
    v = '0;
    if (a == 4'h0) begin
      v = 32'(n);
      if (n == 0)     v = v | 32'h100;
      if (n == DEPTH) v = v | 32'h200;
      if (m_ovf)      v = v | 32'h400;
    end else if (a >= 4'h1 && a <= 4'h6) begin
      if (n != 0) begin
        hd = mq[0];
        v = hd[int'(a) - 1];
      end
    end else if (a == 4'h8) v = m_acc_t[31:0];
    else if (a == 4'h9) v = m_acc_t[63:32];
    else if (a == 4'hA) v = m_acc_a[31:0];
    else if (a == 4'hB) v = m_acc_a[63:32];
    else if (a == 4'hC) v = m_runs;
    return v;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_acc_t = '0;
    m_acc_a = '0;
    m_runs  = '0;
    m_ovf   = 1'b0;
  endtask

  task automatic model_update(input bit md, input rec_t r, input logic [3:0] cmd);
    bit ovf_ev;
    ovf_ev = 1'b0;
    if (cmd[1]) begin
      mq.delete();
    end else begin
      if (cmd[0] && mq.size() > 0) void'(mq.pop_front());
      if (md) begin
        if (mq.size() < DEPTH) mq.push_back(r);
        else ovf_ev = 1'b1;
      end
    end
    if (ovf_ev) m_ovf = 1'b1;
    else if (cmd[2]) m_ovf = 1'b0;
    if (cmd[3]) begin
      m_acc_t = '0;
      m_acc_a = '0;
      m_runs  = '0;
    end else if (md) begin
      m_acc_t = sat_acc(m_acc_t, r[0]);
      m_acc_a = sat_acc(m_acc_a, r[1]);
      if (m_runs != 32'hFFFF_FFFF) m_runs = m_runs + 1;
    end
  endtask

  // One clock of stimulus: drive, clock, then compare against the model.
  task automatic step(input bit md, input rec_t r, input bit wr, input bit rd,
                      input logic [3:0] addr, input logic [31:0] wdata, input string tag);
    logic [31:0] exp_rd;
    bit          exp_irq;
    logic [3:0]  cmd;
    exp_rd  = model_read(addr);
    exp_irq = (mq.size() != 0);
    cmd     = (wr && addr == 4'h7) ? wdata[3:0] : 4'h0;
    measurement_done    = md;
    total_cycles_count  = r[0];
    active_cycles_count = r[1];
    idle_cycles_count   = r[2];
    cache_hit_count     = r[3];
    cache_miss_count    = r[4];
    decode_count        = r[5];
    csr_wr_en   = wr;
    csr_rd_en   = rd;
    csr_addr    = addr;
    csr_wr_data = wdata;
    @(posedge clk);
    #1;
    measurement_done = 1'b0;
    csr_wr_en = 1'b0;
    csr_rd_en = 1'b0;
    model_update(md, r, cmd);
    chk({tag, "_irq"}, 32'(irq_pending), 32'(exp_irq));
    if (rd) begin
      chk({tag, "_valid"}, 32'(csr_rd_valid), 32'd1);
      chk({tag, "_data"}, csr_rd_data, exp_rd);
      last_rd = csr_rd_data;
    end else begin
      chk({tag, "_valid_idle"}, 32'(csr_rd_valid), 32'd0);
    end
  endtask

  task automatic push(input rec_t r);
    step(1'b1, r, 1'b0, 1'b0, 4'h0, 32'h0, "push");
  endtask

  task automatic ctrl(input logic [3:0] bits);
    step(1'b0, zrec, 1'b1, 1'b0, 4'h7, 32'(bits), "ctrl");
  endtask

  task automatic rd(input logic [3:0] a, input string tag);
    step(1'b0, zrec, 1'b0, 1'b1, a, 32'h0, tag);
  endtask

  initial begin
    zrec = mk(0, 0, 0, 0, 0, 0);
    model_reset();
    last_rd = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rd_data", csr_rd_data, 32'h0);
    chk("reset_rd_valid", 32'(csr_rd_valid), 32'd0);
    chk("reset_irq", 32'(irq_pending), 32'd0);
    rst_n = 1'b1;

    rd(4'h0, "status_after_reset");
    chk("status_after_reset_lit", last_rd, 32'h100);

    // Single run
    push(mk(100, 80, 0, 7, 0, 0));
    rd(4'h0, "single_status");
    chk("single_level_lit", last_rd, 32'h1);
    rd(4'h1, "single_total");
    chk("single_total_lit", last_rd, 32'd100);
    rd(4'h2, "single_active");
    rd(4'h4, "single_hits");
    chk("single_hits_lit", last_rd, 32'd7);
    rd(4'hC, "single_runs");
    chk("single_runs_lit", last_rd, 32'd1);
    rd(4'h7, "ctrl_reads_zero");

    // Fill plus one
    ctrl(4'hE);
    for (int i = 1; i <= 5; i++) push(mk(32'(i), 0, 0, 0, 0, 0));
    rd(4'h0, "fill_status");
    chk("fill_status_lit", last_rd, 32'h604);
    rd(4'h1, "fill_head");
    chk("fill_head_lit", last_rd, 32'd1);
    for (int i = 0; i < 4; i++) ctrl(4'h1);
    rd(4'h1, "drained_head");
    chk("drained_head_lit", last_rd, 32'd0);
    rd(4'h0, "drained_status");
    chk("drained_status_lit", last_rd, 32'h500);
    rd(4'h8, "fill_acc");
    chk("fill_acc_lit", last_rd, 32'd15);
    ctrl(4'h1); // pop while empty: no overflow change
    rd(4'h0, "pop_empty_status");

    // Pop + push while full
    ctrl(4'hE);
    for (int i = 10; i <= 13; i++) push(mk(32'(i), 32'(i + 1), 0, 0, 0, 0));
    step(1'b1, mk(14, 15, 0, 0, 0, 0), 1'b1, 1'b0, 4'h7, 32'h1, "popush_full");
    rd(4'h0, "popush_status");
    chk("popush_status_lit", last_rd, 32'h204);
    rd(4'h1, "popush_head");
    chk("popush_head_lit", last_rd, 32'd11);

    // Pop + push while empty
    ctrl(4'h2);
    step(1'b1, mk(77, 0, 0, 0, 0, 0), 1'b1, 1'b0, 4'h7, 32'h1, "popush_empty");
    rd(4'h0, "popush_empty_status");
    chk("popush_empty_level_lit", last_rd, 32'h1);
    // Read issued with a same-cycle push sees pre-push head
    ctrl(4'h2);
    step(1'b1, mk(55, 0, 0, 0, 0, 0), 1'b0, 1'b1, 4'h1, 32'h0, "rd_with_push");
    chk("rd_with_push_lit", last_rd, 32'd0);

    // Saturation
    force dut.acc_total = 64'hFFFF_FFFF_FFFF_FFFE;
    #1;
    release dut.acc_total;
    m_acc_t = 64'hFFFF_FFFF_FFFF_FFFE;
    push(mk(5, 0, 0, 0, 0, 0));
    rd(4'h8, "sat_lo");
    chk("sat_lo_lit", last_rd, 32'hFFFF_FFFF);
    rd(4'h9, "sat_hi");
    chk("sat_hi_lit", last_rd, 32'hFFFF_FFFF);

    // Clear races
    push(mk(3, 3, 3, 3, 3, 3));
    step(1'b1, mk(9, 9, 9, 9, 9, 9), 1'b1, 1'b0, 4'h7, 32'h2, "clrfifo_push");
    rd(4'h0, "clrfifo_status");
    chk("clrfifo_level_lit", last_rd & 32'h1F, 32'h0);
    step(1'b1, mk(1000, 500, 0, 0, 0, 0), 1'b1, 1'b0, 4'h7, 32'h8, "clracc_md");
    rd(4'h8, "clracc_lo");
    chk("clracc_lo_lit", last_rd, 32'h0);
    rd(4'hA, "clracc_act");
    rd(4'hC, "clracc_runs");
    for (int i = 0; i < 4; i++) push(mk(32'(20 + i), 0, 0, 0, 0, 0));
    ctrl(4'h4);
    step(1'b1, mk(99, 0, 0, 0, 0, 0), 1'b1, 1'b0, 4'h7, 32'h4, "clrovf_ovfpush");
    rd(4'h0, "clrovf_status");
    chk("clrovf_ovf_lit", (last_rd >> 10) & 32'h1, 32'h1);
    step(1'b0, zrec, 1'b1, 1'b0, 4'h3, 32'hF, "wr_other_addr");
    rd(4'h0, "wr_other_status");

    // Asynchronous reset with entries queued
    ctrl(4'hE);
    for (int i = 0; i < 3; i++) push(mk(32'(60 + i), 1, 2, 3, 4, 5));
    rd(4'h1, "pre_reset_head");
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_rd_data", csr_rd_data, 32'h0);
    chk("async_rst_rd_valid", 32'(csr_rd_valid), 32'd0);
    chk("async_rst_irq", 32'(irq_pending), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push(mk(42, 0, 0, 0, 0, 0));
    rd(4'h1, "post_reset_head");
    chk("post_reset_head_lit", last_rd, 32'd42);
    rd(4'h0, "post_reset_status");
    chk("post_reset_level_lit", last_rd, 32'h1);
    ctrl(4'hF);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      bit          md;
      bit          wr;
      bit          rdv;
      logic [3:0]  a;
      logic [31:0] wd;
      rec_t        r;
      md  = ($urandom_range(0, 1) == 1);
      wr  = ($urandom_range(0, 9) < 4);
      rdv = ($urandom_range(0, 3) != 0);
      r   = mk($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
      a   = 4'($urandom_range(0, 15));
      if (wr && $urandom_range(0, 3) != 0) a = 4'h7;
      wd = $urandom & 32'hFFFF_FFF0;
      if ($urandom_range(0, 9) < 7)  wd[0] = 1'b1;
      if ($urandom_range(0, 19) == 0) wd[1] = 1'b1;
      if ($urandom_range(0, 9) == 0)  wd[2] = 1'b1;
      if ($urandom_range(0, 29) == 0) wd[3] = 1'b1;
      step(md, r, wr, rdv, a, wd, "rand");
    end
    for (int a = 0; a < 16; a++) rd(4'(a), "final_sweep");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/perf_history.md
# perf_history

Downstream consumer of the performance monitor. Captures every completed measurement record (six counters, qualified by the `measurement_done` pulse) into a small snapshot FIFO. Keeps saturating lifetime accumulators across runs. Exposes everything to software through a word-addressed CSR read/write port, so back-to-back inference runs are not lost between software polls.

## Interface
- `COUNTER_WIDTH`, default 32: width of incoming counters; legal range 1..32; values zero-extended to 32 on readout.
- `DEPTH`, default 4: snapshot FIFO entries; power of two, 2..16.
- `clk` in 1: system clock.
- `rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `measurement_done` in 1: single-cycle pulse; the six count inputs are valid in this cycle.
- `total_cycles_count`, `active_cycles_count`, `idle_cycles_count` in COUNTER_WIDTH: run cycle counts.
- `cache_hit_count`, `cache_miss_count`, `decode_count` in COUNTER_WIDTH: metadata counts.
- `csr_wr_en` in 1: write strobe.
- `csr_rd_en` in 1: read strobe.
- `csr_addr` in 4: word address, shared by read and write.
- `csr_wr_data` in 32: write data.
- `csr_rd_data` out 32: registered read data.
- `csr_rd_valid` out 1: high the cycle after `csr_rd_en`.
- `irq_pending` out 1: high while the FIFO is non-empty.

## Operation
- Register map (read):
  - 0x0 STATUS: [4:0] level, [8] empty, [9] full, [10] overflow (sticky).
  - 0x1–0x6: head entry total/active/idle/hits/misses/decode. All read 0 when the FIFO is empty.
  - 0x8/0x9: ACC_TOTAL lo/hi.
  - 0xA/0xB: ACC_ACTIVE lo/hi.
  - 0xC: RUN_COUNT.
  - All other addresses read 0. Reads have no side effects.
- Write 0x7 CTRL; bits act as one-cycle commands and read back 0:
  - [0] pop
  - [1] clear_fifo
  - [2] clear_overflow
  - [3] clear_accum
- Writes to any other address are ignored.
- Push: on `measurement_done`, the six inputs are written at the tail and level is incremented.
- Overflow: push while full with no same-cycle pop drops the new record, sets overflow, and leaves FIFO contents unchanged.
- Pop: removes the head. Pop when empty is a no-op and does not set overflow.
- Accumulators:
  - ACC_TOTAL (64b) += total and ACC_ACTIVE (64b) += active on every `measurement_done`, including when the record is dropped.
  - RUN_COUNT (32b) += 1 on every `measurement_done`.
  - All three saturate at all-ones.
- Simultaneous events, in priority order:
  - clear_fifo + push in the same cycle: FIFO empty afterwards; record dropped; overflow unchanged.
  - pop + push while full: both take effect; level stays DEPTH; no overflow.
  - pop + push while empty: push only; level becomes 1.
  - clear_accum + `measurement_done`: accumulators become 0; the sample is not accumulated.
  - clear_overflow + an overflowing push: overflow ends set (set wins).
- Pointers wrap modulo DEPTH. Level is DEPTH+1 values wide, 0..DEPTH.

## Timing
- Reset values: `csr_rd_data`=0, `csr_rd_valid`=0, `irq_pending`=0; pointers, level, overflow and accumulators all 0. Storage contents are don't-care.
- Read latency is 1 cycle.
- `csr_rd_data` reflects state before any same-cycle write or push. Example: a read of 0x1 together with a pop returns the popped entry.
- Push, pop and clear are visible to a read issued the next cycle.
- `irq_pending` is registered and updates the cycle after a level change.
- Reset mid-operation discards all entries and accumulators immediately (asynchronous). The first push after deassertion lands at entry 0.
- Accepts `measurement_done` on consecutive cycles; there is no throughput restriction.

## Structure
- Shared package `perf_pkg` holds:
  - CSR address localparams (`PERF_HIST_STATUS` … `PERF_HIST_RUNCNT`).
  - CTRL bit indices.
  - STATUS bit positions.
  - The `perf_record_t` packed struct (six 32b fields).
- Sub-module `perf_hist_fifo` is a synchronous FIFO of `perf_record_t`. It provides push, pop and clear, plus full/empty/level and an overflow pulse, and holds the priority rules above.
- The top holds CSR decode, the accumulators and the read mux.

## Test plan
- Single run: total=100, active=80, hits=7 pulsed once → STATUS level=1, 0x1 reads 100, 0x2 reads 80, 0x4 reads 7, RUN_COUNT=1, `irq_pending`=1 the next cycle.
- Fill plus one: 5 pushes with DEPTH=4, totals 1..5 → full=1, overflow=1; head reads 1; after 4 pops head reads 0, empty=1; ACC_TOTAL=15.
- Pop and push same cycle while full → level stays 4, overflow stays 0; head advances by one record.
- Saturation: preload by pushing total=0xFFFFFFFF repeatedly (or force the accumulator to 2^64−2), push total=5 → ACC hi/lo read 0xFFFFFFFF/0xFFFFFFFF.
- Clear races: clear_fifo together with a push → level 0. clear_accum together with `measurement_done` → ACC reads 0. clear_overflow together with an overflowing push → overflow=1.
- Assert `rst_n` with 3 entries queued → outputs 0 asynchronously; after release, one push of total=42 → head 42, level 1.
